// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad encoder: FSM states,
// key codes, the (row, col) key map and small one-hot/priority helpers.
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, STROBE, WAIT_RELEASE} kp_state_t;

  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;

  // Indexed by {row_idx, col_idx}; element 0 is the rightmost entry.
  localparam logic [15:0][3:0] KEY_MAP = {
    KEY_D, KEY_HASH, 4'd0, KEY_STAR,   // row 3: *, 0, #, D
    KEY_C, 4'd9,     4'd8, 4'd7,       // row 2: 7, 8, 9, C
    KEY_B, 4'd6,     4'd5, 4'd4,       // row 1: 4, 5, 6, B
    KEY_A, 4'd3,     4'd2, 4'd1        // row 0: 1, 2, 3, A
  };

  function automatic logic [1:0] lowest_col(input logic [3:0] cols);
    if (cols[0])      lowest_col = 2'd0;
    else if (cols[1]) lowest_col = 2'd1;
    else if (cols[2]) lowest_col = 2'd2;
    else              lowest_col = 2'd3;
  endfunction

  function automatic logic [1:0] row_index(input logic [3:0] rows_oh);
    case (rows_oh)
      4'b0010: row_index = 2'd1;
      4'b0100: row_index = 2'd2;
      4'b1000: row_index = 2'd3;
      default: row_index = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Parameterized-width two-flop synchronizer for asynchronous inputs;
// both stages reset to 0.
module keypad_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] ff1_q;
  logic [WIDTH-1:0] ff2_q;

  // NOTE: non-blocking assignments make both stages sample the pre-edge
  // values; blocking ones would collapse the chain into a single flop.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ff1_q <= '0;
      ff2_q <= '0;
    end else begin
      ff1_q <= d;
      ff2_q <= ff1_q;
    end
  end

  assign q = ff2_q;

endmodule

// File: rtl/keypad_encoder.sv
// 4x4 matrix keypad scanner: rotates a one-hot row drive, debounces the
// synchronized column returns and emits a one-cycle keystrobe per press.
module keypad_encoder
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [3:0] columns,
  output logic [3:0] rows,
  output logic [3:0] keycode,
  output logic       keystrobe
);

  localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  kp_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       rows_q, rows_d;
  logic [1:0]       col_q, col_d;
  logic [3:0]       keycode_q, keycode_d;
  logic             keystrobe_q, keystrobe_d;

  logic [3:0] col_sync;
  logic       col_bit;
  logic [1:0] row_idx;
  logic [3:0] rows_rot;
  logic       scan_done;
  logic       deb_done;

  keypad_sync #(.WIDTH(4)) u_col_sync (
    .clk  (clk),
    .nrst (nrst),
    .d    (columns),
    .q    (col_sync)
  );

  assign col_bit   = col_sync[col_q];
  assign row_idx   = row_index(rows_q);
  assign rows_rot  = {rows_q[2:0], rows_q[3]};
  assign scan_done = (cnt_q == SCAN_LAST);
  assign deb_done  = (cnt_q == DEB_LAST);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= SCAN;
      cnt_q       <= '0;
      rows_q      <= 4'b0001;
      col_q       <= 2'd0;
      keycode_q   <= 4'h0;
      keystrobe_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rows_q      <= rows_d;
      col_q       <= col_d;
      keycode_q   <= keycode_d;
      keystrobe_q <= keystrobe_d;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SCAN:         if (scan_done && (col_sync != 4'b0000)) state_d = DEBOUNCE;
      DEBOUNCE:     if (!col_bit) state_d = SCAN;
                    else if (deb_done) state_d = STROBE;
      STROBE:       state_d = WAIT_RELEASE;
      WAIT_RELEASE: if (!col_bit && deb_done) state_d = SCAN;
      default:      state_d = SCAN;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    rows_d      = rows_q;
    col_d       = col_q;
    keycode_d   = keycode_q;
    keystrobe_d = 1'b0;
    case (state_q)
      SCAN: begin
        if (scan_done) begin
          cnt_d = '0;
          if (col_sync != 4'b0000) col_d  = lowest_col(col_sync);
          else                     rows_d = rows_rot;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DEBOUNCE: begin
        if (!col_bit) begin
          cnt_d  = '0;
          rows_d = rows_rot;
        end else if (deb_done) begin
          cnt_d       = '0;
          keystrobe_d = 1'b1;
          keycode_d   = KEY_MAP[{row_idx, col_q}];
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STROBE: cnt_d = '0;
      WAIT_RELEASE: begin
        // Any return of the watched column restarts the release window.
        if (col_bit) begin
          cnt_d = '0;
        end else if (deb_done) begin
          cnt_d  = '0;
          rows_d = rows_rot;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  assign rows      = rows_q;
  assign keycode   = keycode_q;
  assign keystrobe = keystrobe_q;

endmodule
